// File: rtl/dex_pipe.sv
// Elastic decode-to-execute stage: DEPTH-entry circular buffer with valid/ready
// handshake, synchronous flush and zeroed bubble payload. Optional DEX_PERF_EN adds perf counters.
module dex_pipe #(
    parameter int unsigned REGI_BITS = 4,
    parameter int unsigned VECT_BITS = 2,
    parameter int unsigned REGI_SIZE = 16,
    parameter int unsigned VECT_SIZE = 8,
    parameter int unsigned ELEM_SIZE = 8,
    parameter int unsigned CTRL_BITS = 40,
    parameter int unsigned DEPTH     = 2,
    localparam int unsigned VW       = ELEM_SIZE * VECT_SIZE,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [REGI_SIZE-1:0] int_oper1_i,
    input  logic [REGI_SIZE-1:0] int_oper2_i,
    input  logic [VW-1:0]        vec_oper1_i,
    input  logic [VW-1:0]        vec_oper2_i,
    input  logic [CTRL_BITS-1:0] ctrl_i,
    input  logic [REGI_BITS-1:0] int_dest_i,
    input  logic [VECT_BITS-1:0] vec_dest_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [REGI_SIZE-1:0] int_oper1_o,
    output logic [REGI_SIZE-1:0] int_oper2_o,
    output logic [VW-1:0]        vec_oper1_o,
    output logic [VW-1:0]        vec_oper2_o,
    output logic [CTRL_BITS-1:0] ctrl_o,
    output logic [REGI_BITS-1:0] int_dest_o,
    output logic [VECT_BITS-1:0] vec_dest_o,
    output logic [CW-1:0]        count_o
`ifdef DEX_PERF_EN
    ,
    output logic [15:0]          stall_cnt_o,
    output logic [15:0]          flush_cnt_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [REGI_SIZE-1:0] r_i1   [DEPTH];
    logic [REGI_SIZE-1:0] r_i2   [DEPTH];
    logic [VW-1:0]        r_v1   [DEPTH];
    logic [VW-1:0]        r_v2   [DEPTH];
    logic [CTRL_BITS-1:0] r_ctrl [DEPTH];
    logic [REGI_BITS-1:0] r_id   [DEPTH];
    logic [VECT_BITS-1:0] r_vd   [DEPTH];

    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Ready depends only on registered occupancy, never on out_ready_i
    assign in_ready_o  = rst_i && !flush_i && (r_count < CW'(DEPTH));
    assign out_valid_o = (r_count != '0);
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i && !flush_i;
    assign count_o     = r_count;

    // Empty stage presents an all-zero NOP bubble
    assign int_oper1_o = out_valid_o ? r_i1[r_rp]   : '0;
    assign int_oper2_o = out_valid_o ? r_i2[r_rp]   : '0;
    assign vec_oper1_o = out_valid_o ? r_v1[r_rp]   : '0;
    assign vec_oper2_o = out_valid_o ? r_v2[r_rp]   : '0;
    assign ctrl_o      = out_valid_o ? r_ctrl[r_rp] : '0;
    assign int_dest_o  = out_valid_o ? r_id[r_rp]   : '0;
    assign vec_dest_o  = out_valid_o ? r_vd[r_rp]   : '0;

    // Payload storage carries no reset; contents are qualified by count
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_i1[r_wp]   <= int_oper1_i;
            r_i2[r_wp]   <= int_oper2_i;
            r_v1[r_wp]   <= vec_oper1_i;
            r_v2[r_wp]   <= vec_oper2_i;
            r_ctrl[r_wp] <= ctrl_i;
            r_id[r_wp]   <= int_dest_i;
            r_vd[r_wp]   <= vec_dest_i;
        end
    end

    // Pointers and occupancy; flush overrides any handshake in the same cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= PW'(r_wp + 1'b1);
            if (w_pop)  r_rp <= PW'(r_rp + 1'b1);
            case ({w_push, w_pop})
                2'b10:   r_count <= CW'(r_count + 1'b1);
                2'b01:   r_count <= CW'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DEX_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic [16:0] w_flush_sum;

    assign w_flush_sum = 17'(r_flush_cnt) + 17'(r_count);
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

    // Saturating perf counters: head-blocked cycles and beats discarded by flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= 16'(r_stall_cnt + 1'b1);
            if (flush_i)
                r_flush_cnt <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
        end
    end
`endif

endmodule

// File: doc/dex_pipe.md
# dex_pipe

Elastic decode-to-execute pipeline stage for the vector/scalar core. It sits between `superDecoder` and `superExecute` and replaces the fixed single-register hand-off with a `DEPTH`-entry buffer using a valid/ready handshake. It adds synchronous flush for taken jumps and zero-payload bubble output when empty. Operand widths, control-word width and buffer depth are parameters.

## Interface
- `REGI_BITS`, 4, integer register index width
- `VECT_BITS`, 2, vector register index width
- `REGI_SIZE`, 16, integer operand width
- `VECT_SIZE`, 8, elements per vector
- `ELEM_SIZE`, 8, element width; vector operand width `VW = ELEM_SIZE*VECT_SIZE`
- `CTRL_BITS`, 40, packed decoder control word width (opcode, cond, imm, jump address, enables, flags)
- `DEPTH`, 2, buffer entries; power of two, ≥2; `CW = $clog2(DEPTH+1)`

Ports:
- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: asynchronous, active-low reset
- `in_valid_i` in 1: decoder beat valid
- `in_ready_o` out 1: stage accepts a beat
- `int_oper1_i`, `int_oper2_i` in `REGI_SIZE`: integer operands
- `vec_oper1_i`, `vec_oper2_i` in `VW`: vector operands
- `ctrl_i` in `CTRL_BITS`: control word; all-zero means NOP
- `int_dest_i` in `REGI_BITS`: integer destination index
- `vec_dest_i` in `VECT_BITS`: vector destination index
- `flush_i` in 1: discard all buffered beats
- `out_valid_o` out 1: head beat valid
- `out_ready_i` in 1: execute consumes the head beat
- `int_oper1_o`, `int_oper2_o`, `vec_oper1_o`, `vec_oper2_o`, `ctrl_o`, `int_dest_o`, `vec_dest_o` out: head-entry payload, same widths as the inputs
- `count_o` out `CW`: occupied entries
- `stall_cnt_o` out 16: only with `DEX_PERF_EN`
- `flush_cnt_o` out 16: only with `DEX_PERF_EN`

## Operation
- Storage is a circular buffer with `DEPTH` payload entries, a write pointer `wp`, a read pointer `rp`, each `$clog2(DEPTH)` bits wide, and `count`.
- Push: `in_valid_i && in_ready_o`. The payload is written at `wp`, and `wp` increments modulo `DEPTH`.
- Pop: `out_valid_o && out_ready_i`. `rp` increments modulo `DEPTH`.
- `in_ready_o = rst_i && !flush_i && (count < DEPTH)`.
  - Purely registered-state based, so there is no combinational path from `out_ready_i`.
  - Full plus simultaneous pop: `in_ready_o` stays 0 (no pass-through).
- `out_valid_o = (count != 0)`.
- Payload outputs:
  - When `out_valid_o = 1`, they come from entry `rp`.
  - When `out_valid_o = 0`, every payload output is forced to zero (NOP bubble), so execute never sees stale data.
- Count update:
  - Push only: `count+1`.
  - Pop only: `count-1`.
  - Push and pop together: unchanged.
- Flush:
  - On the next edge, `count`, `wp` and `rp` go to 0.
  - Flush dominates push and pop in the same cycle: no beat is accepted, and any pop handshake is ignored.
- The `ctrl_i` contents are opaque. The stage never decodes or modifies them.

## Timing
- Reset (`rst_i` low, async): `count=0`, `wp=rp=0`, `out_valid_o=0`, all payload outputs 0, `in_ready_o=0`, perf counters 0. Entry contents are don't-care.
- After `rst_i` rises, `in_ready_o=1` in the same cycle.
- Latency: a beat pushed at edge N is visible on the outputs with `out_valid_o=1` after edge N (one cycle). There is no bypass.
- Throughput: one beat per cycle while `out_ready_i=1`.
- Reset asserted mid-stream: all buffered beats are lost immediately, with no partial output.
- Wrap-around: pointers roll from `DEPTH-1` to 0 with no gap. `count` never exceeds `DEPTH`.

## Configuration
- `DEX_PERF_EN` defined: the `stall_cnt_o` and `flush_cnt_o` ports and registers exist.
  - `stall_cnt_o` increments by 1 each cycle with `out_valid_o && !out_ready_i`.
  - `flush_cnt_o` adds `count` (beats discarded) on each flush cycle.
  - Both saturate at 16'hFFFF and reset to 0.
- `DEX_PERF_EN` undefined: neither port nor the registers exist. Buffer behaviour is identical.

## Test plan
- Reset, then drive `in_valid_i=1` with `ctrl_i=1`, `int_oper1_i=16'h00A5`, `out_ready_i=1` -> one cycle later `out_valid_o=1`, `int_oper1_o=16'h00A5`; steady one beat per cycle.
- Hold `out_ready_i=0` and push 3 beats with `DEPTH=2` -> `count_o=2`, `in_ready_o=0`, third beat not accepted; head payload stable. With `DEX_PERF_EN`, `stall_cnt_o` increases by 1 per held cycle.
- Full buffer with `out_ready_i=1` and `in_valid_i=1` -> cycle 1: pop only, `count_o=1`; next cycle: push and pop together, `count_o` stays 1.
- `flush_i=1` with `count_o=2` and `in_valid_i=1` -> next cycle `count_o=0`, `out_valid_o=0`, all outputs 0, input beat dropped; `flush_cnt_o=2`.
- Push 5 beats with values 1..5 through `DEPTH=4` while toggling `out_ready_i` -> outputs emerge 1..5 in order across pointer wrap, with no duplicate and no loss.
- Drop `rst_i` while `count_o=2` -> immediately `out_valid_o=0`, `in_ready_o=0`, payload 0; after release `count_o=0`.
